// File: rtl/spi_regfile.sv
// spi_regfile -- SPI (mode 0) slave giving read/write access to a bank of
// DATA_W-bit registers. All SPI pins are synchronised into the clk domain.
// Each frame has an 8-bit command (bit 7 = write, bits 6:0 = address)
// followed by DATA_W data bits, MSB first.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   sck, mosi, ncs    asynchronous SPI slave inputs
//   status[7:0]       byte shifted out during the command phase
//   miso, miso_oe     SPI data out and its output enable
//   q_c[7:0]          last complete command byte
//   q                 all registers, register k at [k*DATA_W +: DATA_W]
//   wr_stb, wr_addr   one-clk pulse and address of each committed write
//   frame_err         one-clk pulse for each rejected frame
module spi_regfile #(
  parameter int                DATA_W    = 32,
  parameter int                N_REGS    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sck,
  input  logic                     mosi,
  input  logic                     ncs,
  input  logic [7:0]               status,
  output logic                     miso,
  output logic                     miso_oe,
  output logic [7:0]               q_c,
  output logic [N_REGS*DATA_W-1:0] q,
  output logic                     wr_stb,
  output logic [6:0]               wr_addr,
  output logic                     frame_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [6:0] LAST_CMD_BIT  = 7'd7;
  localparam logic [6:0] LAST_DATA_BIT = 7'(DATA_W - 1);
  localparam logic [7:0] N_REGS_B      = 8'(N_REGS);

  state_t              state_r, state_nx;
  logic                sck_s1_r, sck_s2_r, sck_d_r;
  logic                mosi_s1_r, mosi_s2_r;
  logic                ncs_s1_r, ncs_s2_r, ncs_d_r;
  logic [1:0]          fill_r;
  logic                armed_r;
  logic                sck_rise_s, sck_fall_s;
  logic                start_s, end_s, err_s, commit_s;
  logic                addr_ok_s;
  logic [6:0]          cmd_addr_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic [DATA_W-1:0]   regs_r [N_REGS];
  logic [DATA_W-1:0]   tx_r;
  logic [DATA_W-2:0]   rx_r;
  logic [DATA_W-1:0]   stage_r;
  logic [6:0]          bit_cnt_r;
  logic                long_r;
  logic                miso_r;
  logic [7:0]          q_c_r;
  logic [6:0]          wr_addr_r;
  logic                wr_stb_r;
  logic                frame_err_r;

  // Two-flop synchronisers, edge-detect delays and the post-reset arming flag.
  // armed_r only rises once a genuinely sampled ncs=1 has passed through the
  // synchroniser, so a frame cut by reset cannot restart until ncs toggles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s1_r  <= 1'b0;
      sck_s2_r  <= 1'b0;
      sck_d_r   <= 1'b0;
      mosi_s1_r <= 1'b0;
      mosi_s2_r <= 1'b0;
      ncs_s1_r  <= 1'b1;
      ncs_s2_r  <= 1'b1;
      ncs_d_r   <= 1'b1;
      fill_r    <= 2'b00;
      armed_r   <= 1'b0;
    end else begin
      sck_s1_r  <= sck;
      sck_s2_r  <= sck_s1_r;
      sck_d_r   <= sck_s2_r;
      mosi_s1_r <= mosi;
      mosi_s2_r <= mosi_s1_r;
      ncs_s1_r  <= ncs;
      ncs_s2_r  <= ncs_s1_r;
      ncs_d_r   <= ncs_s2_r;
      fill_r    <= {fill_r[0], 1'b1};
      armed_r   <= armed_r | (fill_r[1] & ncs_s2_r);
    end
  end

  assign sck_rise_s = sck_s2_r & ~sck_d_r;
  assign sck_fall_s = ~sck_s2_r & sck_d_r;
  // Address of the command byte completing on this sck rising edge.
  assign cmd_addr_s = {rx_r[5:0], mosi_s2_r};
  assign addr_ok_s  = ({1'b0, q_c_r[6:0]} < N_REGS_B);

  // Read mux for the register being addressed; out-of-range reads give 0.
  always_comb begin
    rd_word_s = '0;
    for (int k = 0; k < N_REGS; k++) begin
      rd_word_s = (cmd_addr_s == 7'(k)) ? regs_r[k] : rd_word_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next-state logic; ncs high aborts any active state.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE: state_nx = start_s ? S_CMD : S_IDLE;
      S_CMD: begin
        if (ncs_s2_r) begin
          state_nx = S_IDLE;
        end else if (sck_rise_s && (bit_cnt_r == LAST_CMD_BIT)) begin
          state_nx = S_DATA;
        end else begin
          state_nx = S_CMD;
        end
      end
      S_DATA: begin
        if (ncs_s2_r) begin
          state_nx = S_IDLE;
        end else if (sck_rise_s && (bit_cnt_r == LAST_DATA_BIT)) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_DATA;
        end
      end
      S_DONE:  state_nx = ncs_s2_r ? S_IDLE : S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM output decode: frame start, frame end, reject and commit.
  always_comb begin
    start_s  = 1'b0;
    end_s    = 1'b0;
    err_s    = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      S_IDLE: start_s = armed_r & ncs_d_r & ~ncs_s2_r;
      S_CMD, S_DATA: begin
        end_s = ncs_s2_r;
        err_s = ncs_s2_r;
      end
      S_DONE: begin
        end_s    = ncs_s2_r;
        err_s    = ncs_s2_r & (long_r | ~addr_ok_s);
        commit_s = ncs_s2_r & ~long_r & addr_ok_s & q_c_r[7];
      end
      default: start_s = 1'b0;
    endcase
  end

  // Shift datapath, command latch and the write/error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_r      <= 1'b0;
      tx_r        <= '0;
      rx_r        <= '0;
      stage_r     <= '0;
      bit_cnt_r   <= 7'd0;
      long_r      <= 1'b0;
      q_c_r       <= 8'd0;
      wr_addr_r   <= 7'd0;
      wr_stb_r    <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      wr_stb_r    <= commit_s;
      frame_err_r <= err_s;
      if (commit_s) begin
        wr_addr_r <= q_c_r[6:0];
      end
      if (start_s) begin
        // status[7] goes out immediately; the rest waits in the top of tx_r
        miso_r    <= status[7];
        tx_r      <= DATA_W'({status[6:0], 1'b0}) << (DATA_W - 8);
        rx_r      <= '0;
        bit_cnt_r <= 7'd0;
        long_r    <= 1'b0;
      end else if (end_s || (state_r == S_IDLE) || (state_r == S_DONE)) begin
        miso_r <= 1'b0;
        if ((state_r == S_DONE) && sck_rise_s && !end_s) begin
          long_r <= 1'b1;
        end
      end else if (sck_rise_s) begin
        rx_r <= {rx_r[DATA_W-3:0], mosi_s2_r};
        if ((state_r == S_CMD) && (bit_cnt_r == LAST_CMD_BIT)) begin
          q_c_r     <= {rx_r[6:0], mosi_s2_r};
          tx_r      <= rd_word_s;
          bit_cnt_r <= 7'd0;
        end else if ((state_r == S_DATA) && (bit_cnt_r == LAST_DATA_BIT)) begin
          stage_r   <= {rx_r, mosi_s2_r};
          miso_r    <= 1'b0;
          bit_cnt_r <= 7'd0;
        end else begin
          bit_cnt_r <= bit_cnt_r + 7'd1;
        end
      end else if (sck_fall_s) begin
        miso_r <= tx_r[DATA_W-1];
        tx_r   <= {tx_r[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Register bank: changes only on reset or a committed write.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_REGS; k++) begin
      if (rst) begin
        regs_r[k] <= RESET_VAL;
      end else if (commit_s && (q_c_r[6:0] == 7'(k))) begin
        regs_r[k] <= stage_r;
      end
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_flat
    assign q[g*DATA_W +: DATA_W] = regs_r[g];
  end

  assign miso      = miso_r;
  assign miso_oe   = ~ncs_s2_r;
  assign q_c       = q_c_r;
  assign wr_stb    = wr_stb_r;
  assign wr_addr   = wr_addr_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: a 32-bit/4-register instance driven from a
// vector table plus hand sequences, and a 16-bit/2-register instance.
module tb_spi_regfile;

  logic         clk = 1'b0;
  logic         rst;
  logic         sck, mosi, ncs, ncs16;
  logic [7:0]   status;
  logic         miso, miso_oe, wr_stb, frame_err;
  logic [7:0]   q_c;
  logic [127:0] q;
  logic [6:0]   wr_addr;
  logic         miso16, miso_oe16, wr_stb16, frame_err16;
  logic [7:0]   q_c16;
  logic [31:0]  q16;
  logic [6:0]   wr_addr16;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0, err_cnt = 0, wr_cnt16 = 0, err_cnt16 = 0;

  spi_regfile #(.DATA_W(32), .N_REGS(4), .RESET_VAL(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .ncs(ncs), .status(status),
    .miso(miso), .miso_oe(miso_oe), .q_c(q_c), .q(q), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .frame_err(frame_err)
  );

  spi_regfile #(.DATA_W(16), .N_REGS(2), .RESET_VAL(16'h0000)) dut16 (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .ncs(ncs16), .status(status),
    .miso(miso16), .miso_oe(miso_oe16), .q_c(q_c16), .q(q16), .wr_stb(wr_stb16),
    .wr_addr(wr_addr16), .frame_err(frame_err16)
  );

  always #5 clk = ~clk;

  // pulse counters, sampled on the inactive edge
  always @(negedge clk) begin
    if (wr_stb)      wr_cnt    <= wr_cnt + 1;
    if (frame_err)   err_cnt   <= err_cnt + 1;
    if (wr_stb16)    wr_cnt16  <= wr_cnt16 + 1;
    if (frame_err16) err_cnt16 <= err_cnt16 + 1;
  end

  typedef struct {
    logic [7:0]   status;
    logic [7:0]   cmd;
    logic [63:0]  data;
    int           nbits;
    logic [63:0]  exp_rx;
    int           exp_wr;
    int           exp_err;
    logic [7:0]   exp_qc;
    logic [6:0]   exp_wa;
    logic [127:0] exp_q;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic [7:0] st, input logic [7:0] cmd,
                              input logic [63:0] data, input int nbits,
                              input logic [63:0] exp_rx, input int exp_wr,
                              input int exp_err, input logic [7:0] exp_qc,
                              input logic [6:0] exp_wa, input logic [127:0] exp_q);
    vec_t v;
    v.status = st;   v.cmd = cmd;       v.data = data;     v.nbits = nbits;
    v.exp_rx = exp_rx; v.exp_wr = exp_wr; v.exp_err = exp_err;
    v.exp_qc = exp_qc; v.exp_wa = exp_wa; v.exp_q = exp_q;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One SPI frame: 8 command bits then nbits data bits; sck half period is
  // 8 clk. rst_bit >= 0 pulses rst during the low phase before that bit.
  task automatic spi_frame(input int sel, input logic [7:0] cmd, input logic [63:0] data,
                           input int nbits, input int rst_bit,
                           output logic [7:0] rx_st, output logic [63:0] rx_d,
                           output logic oe_seen);
    logic m;
    rx_st = 8'h00;
    rx_d = 64'h0;
    oe_seen = 1'b0;
    @(negedge clk);
    if (sel == 0) ncs = 1'b0; else ncs16 = 1'b0;
    for (int i = 0; i < 8 + nbits; i++) begin
      if (i < 8) mosi = cmd[7-i];
      else       mosi = data[nbits-1-(i-8)];
      if (i == rst_bit) begin
        rst = 1'b1; #20; rst = 1'b0; #60;
      end else begin
        #80;
      end
      m = (sel == 0) ? miso : miso16;
      if (i == 0) oe_seen = (sel == 0) ? miso_oe : miso_oe16;
      if (i < 8) rx_st = {rx_st[6:0], m};
      else       rx_d  = {rx_d[62:0], m};
      sck = 1'b1; #80; sck = 1'b0;
    end
    #80;
    if (sel == 0) ncs = 1'b1; else ncs16 = 1'b1;
    mosi = 1'b0;
    #200;
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0]  rx_st;
    logic [63:0] rx_d;
    logic        oe;
    int          wr0, err0;
    wr0 = wr_cnt;
    err0 = err_cnt;
    status = v.status;
    spi_frame(0, v.cmd, v.data, v.nbits, -1, rx_st, rx_d, oe);
    chk({tag, "_status_out"}, 128'(rx_st), 128'(v.status));
    chk({tag, "_data_out"},   128'(rx_d),  128'(v.exp_rx));
    chk({tag, "_wr_stb_cnt"}, 128'(wr_cnt - wr0),   128'(v.exp_wr));
    chk({tag, "_frame_err_cnt"}, 128'(err_cnt - err0), 128'(v.exp_err));
    chk({tag, "_q_c"},        128'(q_c), 128'(v.exp_qc));
    chk({tag, "_wr_addr"},    128'(wr_addr), 128'(v.exp_wa));
    chk({tag, "_q"},          q, v.exp_q);
    chk({tag, "_miso_oe_in_frame"}, 128'(oe), 128'(1'b1));
    chk({tag, "_idle_miso"},  128'({miso_oe, miso}), 128'(2'b00));
  endtask

  localparam logic [127:0] Q1 = {32'h0, 32'h0, 32'h0123_4567, 32'h0};
  localparam logic [127:0] Q6 = {32'hCAFE_F00D, 32'h0, 32'h0123_4567, 32'h0};
  localparam logic [127:0] Q7 = {32'hCAFE_F00D, 32'h0, 32'h89AB_CDEF, 32'h0};

  initial begin
    logic [7:0]  rx_st;
    logic [63:0] rx_d;
    logic        oe;
    int          wr0, err0;

    vecs[0] = mk(8'h5A, 8'h00, 64'h0, 32, 64'h0, 0, 0, 8'h00, 7'd0, 128'h0);
    vecs[1] = mk(8'hA5, 8'h81, 64'h0123_4567, 32, 64'h0, 1, 0, 8'h81, 7'd1, Q1);
    vecs[2] = mk(8'h3C, 8'h01, 64'h0, 32, 64'h0123_4567, 0, 0, 8'h01, 7'd1, Q1);
    vecs[3] = mk(8'hC3, 8'h85, 64'hDEAD_BEEF, 32, 64'h0, 0, 1, 8'h85, 7'd1, Q1);
    vecs[4] = mk(8'h0F, 8'h82, 64'hA_BCDE, 20, 64'h0, 0, 1, 8'h82, 7'd1, Q1);
    vecs[5] = mk(8'hF0, 8'h82, 64'h1_2345_6789, 33, 64'h0, 0, 1, 8'h82, 7'd1, Q1);
    vecs[6] = mk(8'h81, 8'h83, 64'hCAFE_F00D, 32, 64'h0, 1, 0, 8'h83, 7'd3, Q6);
    vecs[7] = mk(8'h7E, 8'h81, 64'h89AB_CDEF, 32, 64'h0123_4567, 1, 0, 8'h81, 7'd1, Q7);
    vecs[8] = mk(8'h24, 8'h03, 64'h0, 32, 64'hCAFE_F00D, 0, 0, 8'h03, 7'd1, Q7);
    vecs[9] = mk(8'h99, 8'h7F, 64'h0, 32, 64'h0, 0, 1, 8'h7F, 7'd1, Q7);

    rst = 1'b1; sck = 1'b0; mosi = 1'b0; ncs = 1'b1; ncs16 = 1'b1; status = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    chk("reset_q",        q, 128'h0);
    chk("reset_q16",      128'(q16), 128'h0);
    chk("reset_q_c",      128'(q_c), 128'h0);
    chk("reset_wr_addr",  128'(wr_addr), 128'h0);
    chk("reset_outputs",  128'({miso, miso_oe, wr_stb, frame_err}), 128'(4'b0000));
    chk("reset_pulses",   128'(wr_cnt + err_cnt), 128'h0);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // reset during the data phase of a write to reg 0
    wr0 = wr_cnt;
    err0 = err_cnt;
    status = 8'h11;
    spi_frame(0, 8'h80, 64'hFFFF_FFFF, 32, 18, rx_st, rx_d, oe);
    chk("rst_mid_wr_stb_cnt",    128'(wr_cnt - wr0), 128'h0);
    chk("rst_mid_frame_err_cnt", 128'(err_cnt - err0), 128'h0);
    chk("rst_mid_q",             q, 128'h0);
    chk("rst_mid_q_c",           128'(q_c), 128'h0);
    chk("rst_mid_wr_addr",       128'(wr_addr), 128'h0);
    run_vec(mk(8'h5A, 8'h00, 64'h0, 32, 64'h0, 0, 0, 8'h00, 7'd0, 128'h0), "post_rst_rd0");
    run_vec(mk(8'h6B, 8'h01, 64'h0, 32, 64'h0, 0, 0, 8'h01, 7'd0, 128'h0), "post_rst_rd1");

    // 16-bit instance
    wr0 = wr_cnt16;
    err0 = err_cnt16;
    status = 8'hC6;
    spi_frame(1, 8'h81, 64'hBEEF, 16, -1, rx_st, rx_d, oe);
    chk("w16_status_out",    128'(rx_st), 128'(8'hC6));
    chk("w16_data_out",      128'(rx_d), 128'h0);
    chk("w16_q",             128'(q16), 128'(32'hBEEF_0000));
    chk("w16_wr_stb_cnt",    128'(wr_cnt16 - wr0), 128'd1);
    chk("w16_frame_err_cnt", 128'(err_cnt16 - err0), 128'd0);
    chk("w16_wr_addr",       128'(wr_addr16), 128'd1);
    status = 8'h3A;
    spi_frame(1, 8'h01, 64'h0, 16, -1, rx_st, rx_d, oe);
    chk("r16_data_out",      128'(rx_d), 128'(16'hBEEF));
    chk("r16_q_c",           128'(q_c16), 128'(8'h01));
    chk("r16_miso_oe",       128'(oe), 128'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
